// File: rtl/stream_pkg.sv
// Shared definitions for the streaming datapath: common payload type,
// default buffer depth and a pointer-sizing helper.
package stream_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_FIFO_DEPTH = 8;

    // Address width for a storage array of 'value' entries; never below 1 so
    // that a 2-entry (or degenerate) buffer still gets a legal index vector.
    function automatic int clog2_safe(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port and one
// asynchronous read port, so the head entry can fall through to the output
// in the same cycle its address is presented. Contents are not reset.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    parameter int AW     = clog2_safe(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_fifo_buffer.sv
// Elastic valid/ready FIFO with first-word-fall-through output. Pointers carry
// an extra wrap bit so full and empty are told apart without a counter; a
// separate occupancy register feeds level/almost_full/high_water directly.
module stream_fifo_buffer
    import stream_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = DEF_FIFO_DEPTH,
    parameter int AF_THRESH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   high_water
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_level;
    logic [PW-1:0]     r_high_water;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_level_next;
    logic [PW-1:0]     w_high_water_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // in_ready depends only on state, so a pop cannot open a slot for a push
    // in the same cycle; that keeps in_ready free of any path from out_ready.
    assign w_push = in_valid & ~w_full;
    assign w_pop  = out_ready & ~w_empty;

    // Next occupancy and running maximum from this cycle's handshakes.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + PW'(1);
            2'b01:   w_level_next = r_level - PW'(1);
            default: w_level_next = r_level;
        endcase
        w_high_water_next = r_high_water;
        if (w_level_next > r_high_water) begin
            w_high_water_next = w_level_next;
        end
    end

    // Pointer, level and high-water state; pointers wrap naturally because
    // DEPTH is a power of two, toggling the wrap bit on each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_high_water <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level      <= w_level_next;
            r_high_water <= w_high_water_next;
        end
    end

    stream_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Output is masked while empty so stale storage never shows on out_data
    // and the reset value of out_data is zero.
    assign out_valid   = ~w_empty;
    assign out_data    = w_empty ? '0 : w_rd_data;
    assign in_ready    = ~w_full;
    assign level       = r_level;
    assign almost_full = (r_level >= PW'(AF_THRESH));
    assign high_water  = r_high_water;

    // Protocol invariants.
    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_level <= PW'(DEPTH));
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule
